// File: rtl/seq_det_prog_pkg.sv
// rtl/seq_det_prog_pkg.sv - shared constants and helpers for the programmable sequence detector
// Purpose: default geometry and reset configuration of seq_det_prog, plus the
//          config-length legality check shared by the top level.
// Ports:   none (package)
package seq_det_prog_pkg;

  // Hard ceiling on the history width the detector supports.
  localparam int unsigned SEQ_MAX_LEN_LIMIT = 32;

  localparam int unsigned SEQ_MAX_LEN_DEF = 16;
  localparam int unsigned SEQ_DEF_LEN     = 3;
  localparam logic [SEQ_MAX_LEN_LIMIT-1:0] SEQ_DEF_PATTERN = 32'h0000_0007;
  localparam int unsigned SEQ_CNT_W_DEF   = 8;

  // A pattern length is usable only if it lies within 1..max_len.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// rtl/seq_hist_shreg.sv - serial history shift register with saturating fill counter
// Purpose: keeps the last MAX_LEN received bits (LSB = newest) and how many of
//          them are valid, saturating at the active pattern length.
// Ports:   clk_i/rst_i       clock, synchronous active-high reset
//          shift_i           accept d_i into the history this cycle
//          clear_i           empty history and fill (config reload)
//          drop_fill_i       on a shift, restart fill at 0 instead of advancing
//          d_i               serial data bit
//          len_i             active pattern length (fill saturation point)
//          hist_nxt_o        history as it would be after shifting d_i in
//          fill_nxt_o        fill as it would be after shifting d_i in
module seq_hist_shreg #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               shift_i,
  input  logic               clear_i,
  input  logic               drop_fill_i,
  input  logic               d_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic [MAX_LEN-1:0] hist_nxt_o,
  output logic [LEN_W-1:0]   fill_nxt_o
);

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W:0]     fill_inc;

  // One extra bit so fill+1 cannot wrap when MAX_LEN is one below a power of two.
  assign fill_inc   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
  assign hist_nxt_o = {hist_q[MAX_LEN-2:0], d_i};
  assign fill_nxt_o = (fill_inc >= {1'b0, len_i}) ? len_i : fill_inc[LEN_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_nxt_o;
      fill_q <= drop_fill_i ? '0 : fill_nxt_o;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - runtime-programmable serial bit-sequence detector
// Purpose: flags when the last len valid bits equal the programmed pattern,
//          with overlap/non-overlap mode and a saturating match counter.
// Ports:   clk, rst                 clock, synchronous active-high reset
//          d_in, in_valid           serial data and its qualifier
//          cfg_we, cfg_pattern,
//          cfg_len, cfg_overlap     configuration write port
//          d_out                    one-cycle registered match pulse
//          match_cnt                saturating count of matches since reset
//          cfg_err                  one-cycle pulse on a rejected config write
module seq_det_prog
  import seq_det_prog_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = SEQ_MAX_LEN_DEF,
  parameter int unsigned        DEF_LEN     = SEQ_DEF_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = SEQ_DEF_PATTERN[MAX_LEN-1:0],
  parameter bit                 DEF_OVERLAP = 1'b0,
  parameter int unsigned        CNT_W       = SEQ_CNT_W_DEF,
  localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_in,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               d_out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  if (MAX_LEN < 2 || MAX_LEN > SEQ_MAX_LEN_LIMIT) begin : g_bad_max_len
    $error("seq_det_prog: MAX_LEN out of range 2..32");
  end
  if (DEF_LEN < 1 || DEF_LEN > MAX_LEN) begin : g_bad_def_len
    $error("seq_det_prog: DEF_LEN out of range 1..MAX_LEN");
  end

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               dout_q, dout_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               len_ok;
  logic               cfg_load;
  logic               sample;
  logic               match;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;

  assign len_ok   = len_legal(32'(cfg_len), MAX_LEN);
  assign cfg_load = cfg_we && len_ok;
  // A config write always swallows the coincident data bit, legal or not.
  assign sample   = in_valid && !cfg_we;

  // Bits above the active length take no part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // Judged on the post-shift view so d_out lands exactly one cycle after the completing bit.
  assign match = sample && (((hist_nxt ^ pattern_q) & mask) == '0) && (fill_nxt == len_q);

  seq_hist_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_i     (sample),
    .clear_i     (cfg_load),
    .drop_fill_i (match && !overlap_q),
    .d_i         (d_in),
    .len_i       (len_q),
    .hist_nxt_o  (hist_nxt),
    .fill_nxt_o  (fill_nxt)
  );

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    dout_d    = match;
    err_d     = cfg_we && !len_ok;
    cnt_d     = cnt_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
    end
    if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      dout_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign d_out     = dout_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb/tb_seq_det_prog.sv - scoreboard bench for seq_det_prog
module tb_seq_det_prog;

  logic        clk;
  logic        rst;
  logic        d_in;
  logic        in_valid;
  logic        cfg_we;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic        cfg_overlap;

  logic        d_out,   d_out2;
  logic [7:0]  match_cnt;
  logic [1:0]  match_cnt2;
  logic        cfg_err, cfg_err2;

  int n_tests  = 0;
  int n_failed = 0;

  typedef struct {
    logic       dout;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t exp_q[$];

  seq_det_prog dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .in_valid    (in_valid),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .d_out       (d_out),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  seq_det_prog #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .in_valid    (in_valid),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .d_out       (d_out2),
    .match_cnt   (match_cnt2),
    .cfg_err     (cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: registered outputs are stable at the falling edge after each stimulus edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("d_out",           int'(d_out),      int'(e.dout));
        chk("cfg_err",         int'(cfg_err),    int'(e.err));
        chk("match_cnt",       int'(match_cnt),  int'(e.cnt));
        chk("sat_d_out",       int'(d_out2),     int'(e.dout));
        chk("sat_cfg_err",     int'(cfg_err2),   int'(e.err));
        chk("sat_match_cnt",   int'(match_cnt2), int'(e.cnt2));
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic d, input logic we,
                       input logic [15:0] pat, input logic [4:0] ln, input logic ov,
                       input logic ed, input logic ee, input int ec, input int ec2);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; d_in = d; cfg_we = we;
    cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov;
    @(posedge clk);
    e.dout = ed; e.err = ee; e.cnt = 8'(ec); e.cnt2 = 2'(ec2);
    exp_q.push_back(e);
  endtask

  task automatic bit_in(input logic d, input logic ed, input int ec, input int ec2);
    drive(1'b0, 1'b1, d, 1'b0, 16'h0, 5'd0, 1'b0, ed, 1'b0, ec, ec2);
  endtask

  task automatic gap(input int ec, input int ec2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, ec, ec2);
  endtask

  // Reset with a live valid 1 on the bus: reset must win.
  task automatic do_rst();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 5'd1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic cfg(input logic [15:0] pat, input logic [4:0] ln, input logic ov,
                     input logic ee, input int ec, input int ec2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, pat, ln, ov, 1'b0, ee, ec, ec2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; d_in = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

    // 1: default 111 non-overlap on six 1s
    do_rst();
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(1, 1, 2, 2);

    // 2: 1011 overlapping
    do_rst();
    cfg(16'b1011, 5'd4, 1'b1, 0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(0, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(1, 1, 2, 2);

    // 3: in_valid gap carrying 1s is ignored
    do_rst();
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0);
    gap(0, 0); gap(0, 0); gap(0, 0);
    bit_in(1, 1, 1, 1);

    // 4: illegal lengths rejected, progress kept, sample discarded
    do_rst();
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0);
    cfg(16'h0000, 5'd0, 1'b1, 1, 0, 0);
    bit_in(1, 1, 1, 1);
    cfg(16'h0000, 5'd17, 1'b1, 1, 1, 1);
    bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(1, 1, 2, 2);

    // 5: legal cfg mid-partial clears history
    do_rst();
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0);
    cfg(16'h0007, 5'd3, 1'b0, 0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1);

    // 6: saturation on the 2-bit counter, then reset mid-sequence
    do_rst();
    cfg(16'h0007, 5'd3, 1'b1, 0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1); bit_in(1, 1, 2, 2);
    bit_in(1, 1, 3, 3); bit_in(1, 1, 4, 3); bit_in(1, 1, 5, 3);
    do_rst();
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0);
    do_rst();
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1);

    // 7: len=1 pattern 0, non-overlap
    do_rst();
    cfg(16'hFFFE, 5'd1, 1'b0, 0, 0, 0);
    bit_in(0, 1, 1, 1); bit_in(1, 0, 1, 1); bit_in(0, 1, 2, 2); bit_in(0, 1, 3, 3);

    // 8: len=MAX_LEN boundary accepted
    do_rst();
    cfg(16'hA5C3, 5'd16, 1'b0, 0, 0, 0);
    for (int i = 15; i >= 0; i--) begin
      bit_in(i[0] ? 1'b1 : 1'b0, 1'b0, 0, 0);
    end
    do_rst();
    cfg(16'hA5C3, 5'd16, 1'b0, 0, 0, 0);
    begin
      logic [15:0] p;
      p = 16'hA5C3;
      for (int i = 15; i >= 1; i--) bit_in(p[i], 1'b0, 0, 0);
      bit_in(p[0], 1'b1, 1, 1);
    end

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
        n_tests++;
        n_failed++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
